frame_snapshot_ctrl: RTL

- Double-buffered, frame-synchronous transfer of game state (obstacles, player_y, gamemode) from the 60 Hz game-logic domain into the VGA pixel pipeline.
- Captures a coherent snapshot into a hidden back bank after each game tick.
- Commits the back bank to the display registers atomically at vertical-blank entry, so the screen never shows a torn or mid-update frame.
- Sits between game_logic/map and vga_screen_pic; replaces the per-pixel-clock resampling of game data.

---
 rtl/frame_snapshot_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_snapshot_ctrl.sv
// Double-buffered, frame-synchronous snapshot of game state for the VGA pipeline.
// A back bank is filled after each game tick and committed atomically at vblank entry.
module frame_snapshot_ctrl #(
    parameter int unsigned N_OBS      = 10,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned STABLE_DLY = 4,
    parameter int unsigned RST_X      = 700,
    parameter int unsigned RST_Y      = 500,
    parameter int unsigned RST_PLAYER = 240
) (
    input  logic                 clk,
    input  logic                 rst_n_debounced,
    input  logic                 tick_60hz,
    input  logic                 vblank,
    input  logic [N_OBS*X_W-1:0] obs_x_left_in,
    input  logic [N_OBS*X_W-1:0] obs_x_right_in,
    input  logic [N_OBS*Y_W-1:0] obs_y_up_in,
    input  logic [N_OBS*Y_W-1:0] obs_y_down_in,
    input  logic [Y_W-1:0]       player_y_in,
    input  logic [1:0]           gamemode_in,
    output logic [N_OBS*X_W-1:0] obs_x_left_disp,
    output logic [N_OBS*X_W-1:0] obs_x_right_disp,
    output logic [N_OBS*Y_W-1:0] obs_y_up_disp,
    output logic [N_OBS*Y_W-1:0] obs_y_down_disp,
    output logic [Y_W-1:0]       player_y_disp,
    output logic [1:0]           gamemode_disp,
    output logic                 swap_pulse,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int unsigned DLY_W = (STABLE_DLY > 1) ? $clog2(STABLE_DLY) : 1;

    localparam logic [DLY_W-1:0]     DLY_LOAD  = DLY_W'(STABLE_DLY - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_OBS - 1);
    localparam logic [N_OBS*X_W-1:0] RST_X_VEC = {N_OBS{X_W'(RST_X)}};
    localparam logic [N_OBS*Y_W-1:0] RST_Y_VEC = {N_OBS{Y_W'(RST_Y)}};
    localparam logic [Y_W-1:0]       RST_P_VEC = Y_W'(RST_PLAYER);

    typedef enum logic [1:0] {StIdle, StSettle, StCopy, StReady} state_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tick_s1_q, tick_s2_q, tick_s3_q, vblank_q;
    logic               tick_det, vb_rise;
    logic               copy_en, commit, drop_inc;

    logic [N_OBS*X_W-1:0] bk_xl_q, bk_xr_q, disp_xl_q, disp_xr_q;
    logic [N_OBS*Y_W-1:0] bk_yu_q, bk_yd_q, disp_yu_q, disp_yd_q;
    logic [Y_W-1:0]       bk_py_q, disp_py_q;
    logic [1:0]           bk_gm_q, disp_gm_q;
    logic                 swap_q;
    logic [7:0]           drop_q;

    // Two flops resolve metastability on the raw tick; the third gives edge detection.
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            tick_s1_q <= 1'b0;
            tick_s2_q <= 1'b0;
            tick_s3_q <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            tick_s1_q <= tick_60hz;
            tick_s2_q <= tick_s1_q;
            tick_s3_q <= tick_s2_q;
            vblank_q  <= vblank;
        end
    end

    assign tick_det = tick_s2_q & ~tick_s3_q;
    assign vb_rise  = vblank & ~vblank_q;

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            state_q <= StIdle;
            dly_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        idx_d    = idx_q;
        copy_en  = 1'b0;
        commit   = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick_det) begin
                    state_d = StSettle;
                    dly_d   = DLY_LOAD;
                end
            end
            StSettle: begin
                if (tick_det) begin
                    dly_d = DLY_LOAD;
                end else if (dly_q == '0) begin
                    state_d = StCopy;
                    idx_d   = '0;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            StCopy: begin
                // A new tick abandons the partial bank; it is fully rewritten later.
                if (tick_det) begin
                    state_d = StSettle;
                    dly_d   = DLY_LOAD;
                end else begin
                    copy_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StReady;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StReady: begin
                if (vb_rise) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end else if (tick_det) begin
                    drop_inc = 1'b1;
                end
                if (tick_det) begin
                    state_d = StSettle;
                    dly_d   = DLY_LOAD;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            bk_xl_q <= RST_X_VEC;
            bk_xr_q <= RST_X_VEC;
            bk_yu_q <= RST_Y_VEC;
            bk_yd_q <= RST_Y_VEC;
            bk_py_q <= RST_P_VEC;
            bk_gm_q <= 2'd0;
        end else if (copy_en) begin
            for (int i = 0; i < N_OBS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    bk_xl_q[i*X_W +: X_W] <= obs_x_left_in[i*X_W +: X_W];
                    bk_xr_q[i*X_W +: X_W] <= obs_x_right_in[i*X_W +: X_W];
                    bk_yu_q[i*Y_W +: Y_W] <= obs_y_up_in[i*Y_W +: Y_W];
                    bk_yd_q[i*Y_W +: Y_W] <= obs_y_down_in[i*Y_W +: Y_W];
                end
            end
            if (idx_q == IDX_LAST) begin
                bk_py_q <= player_y_in;
                bk_gm_q <= gamemode_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            disp_xl_q <= RST_X_VEC;
            disp_xr_q <= RST_X_VEC;
            disp_yu_q <= RST_Y_VEC;
            disp_yd_q <= RST_Y_VEC;
            disp_py_q <= RST_P_VEC;
            disp_gm_q <= 2'd0;
            swap_q    <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            swap_q <= commit;
            if (commit) begin
                disp_xl_q <= bk_xl_q;
                disp_xr_q <= bk_xr_q;
                disp_yu_q <= bk_yu_q;
                disp_yd_q <= bk_yd_q;
                disp_py_q <= bk_py_q;
                disp_gm_q <= bk_gm_q;
            end
            if (drop_inc && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign obs_x_left_disp  = disp_xl_q;
    assign obs_x_right_disp = disp_xr_q;
    assign obs_y_up_disp    = disp_yu_q;
    assign obs_y_down_disp  = disp_yd_q;
    assign player_y_disp    = disp_py_q;
    assign gamemode_disp    = disp_gm_q;
    assign swap_pulse       = swap_q;
    assign drop_cnt         = drop_q;

endmodule
